// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : central pipeline sequencer for the 5-stage core
//
// Produces the per-stage stall and flush vectors for the PC register and the
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It arbitrates between
// the redirect and hazard sources: CLINT trap, EX branch, EX multi-cycle busy
// and ID load-use. It also runs the JTAG halt / drain / resume sequence and
// holds on to a branch target that resolves while fetch is frozen.
//
// Vector bit map (stall and flush):
//   0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb
//
// Handshake / timing: there are no valid/ready channels. Every output is
// combinational from the registered state and the current inputs. The
// consumers sample the outputs on the next rising clk edge. i_clint_req is a
// level that the CLINT holds until o_clint_assert has been seen.
//
// Ports:
//   clk               core clock
//   rst_n             asynchronous active-low reset
//   i_jtag_rst        debug reset: FSM back to RUN, branch latch cleared
//   i_jtag_halt_req   level halt request from the debug module
//   o_jtag_halt_ack   high while the core is halted
//   i_load_use        ID-stage load-use hazard
//   i_ex_busy         EX multi-cycle unit (divider) busy
//   i_branch_taken    EX branch/jump resolved taken
//   i_pc_branch       EX branch target
//   i_clint_req       CLINT trap request (level)
//   o_clint_assert    trap redirect to pc_reg
//   o_branch_taken    branch redirect to pc_reg
//   o_pc_branch       branch redirect target to pc_reg
//   o_stall_vec       per-stage hold
//   o_flush_vec       per-stage bubble insert
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int PC_W         = 32,
    parameter int STALL_W      = 5,
    parameter int FLUSH_W      = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_jtag_rst,
    input  logic               i_jtag_halt_req,
    output logic               o_jtag_halt_ack,
    input  logic               i_load_use,
    input  logic               i_ex_busy,
    input  logic               i_branch_taken,
    input  logic [PC_W-1:0]    i_pc_branch,
    input  logic               i_clint_req,
    output logic               o_clint_assert,
    output logic               o_branch_taken,
    output logic [PC_W-1:0]    o_pc_branch,
    output logic [STALL_W-1:0] o_stall_vec,
    output logic [FLUSH_W-1:0] o_flush_vec
);

    // Stage indices into the stall / flush vectors.
    localparam int IDX_PC     = 0;
    localparam int IDX_IF_ID  = 1;
    localparam int IDX_ID_EX  = 2;
    localparam int IDX_EX_MEM = 3;
    localparam int IDX_MEM_WB = 4;

    // Debug FSM states.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_RESUME = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Registered state.
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lat_vld;
    logic [PC_W-1:0]  r_lat_pc;

    // Next-state values.
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_next_lat_vld;
    logic [PC_W-1:0]  w_next_lat_pc;

    // In RUN, a branch only counts when EX is not busy. A busy EX owns the
    // branch unit result, so the branch input is ignored in that case.
    logic w_run_branch;
    // In RUN, the halt request is deferred while a redirect is taken. This
    // lets the redirect land in pc_reg before fetch is frozen.
    logic w_run_redirect;

    assign w_run_branch   = i_branch_taken & ~i_ex_busy;
    assign w_run_redirect = i_clint_req | w_run_branch;

    // -----------------------------------------------------------------------
    // Output and next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        o_stall_vec     = '0;
        o_flush_vec     = '0;
        o_clint_assert  = 1'b0;
        o_branch_taken  = 1'b0;
        o_pc_branch     = '0;
        o_jtag_halt_ack = 1'b0;

        w_next_state    = r_state;
        w_next_cnt      = r_cnt;
        w_next_lat_vld  = r_lat_vld;
        w_next_lat_pc   = r_lat_pc;

        if (i_jtag_rst) begin
            // Debug reset: bubble every pipeline register and go back to RUN.
            o_flush_vec[IDX_IF_ID]  = 1'b1;
            o_flush_vec[IDX_ID_EX]  = 1'b1;
            o_flush_vec[IDX_EX_MEM] = 1'b1;
            o_flush_vec[IDX_MEM_WB] = 1'b1;
            w_next_state            = ST_RUN;
            w_next_cnt              = '0;
            w_next_lat_vld          = 1'b0;
            w_next_lat_pc           = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_clint_req) begin
                        o_clint_assert          = 1'b1;
                        o_flush_vec[IDX_IF_ID]  = 1'b1;
                        o_flush_vec[IDX_ID_EX]  = 1'b1;
                        o_flush_vec[IDX_EX_MEM] = 1'b1;
                    end else if (i_ex_busy) begin
                        o_stall_vec[IDX_PC]     = 1'b1;
                        o_stall_vec[IDX_IF_ID]  = 1'b1;
                        o_stall_vec[IDX_ID_EX]  = 1'b1;
                        o_flush_vec[IDX_EX_MEM] = 1'b1;
                    end else if (i_branch_taken) begin
                        o_branch_taken          = 1'b1;
                        o_pc_branch             = i_pc_branch;
                        o_flush_vec[IDX_IF_ID]  = 1'b1;
                        o_flush_vec[IDX_ID_EX]  = 1'b1;
                    end else if (i_load_use) begin
                        o_stall_vec[IDX_PC]     = 1'b1;
                        o_stall_vec[IDX_IF_ID]  = 1'b1;
                        o_flush_vec[IDX_ID_EX]  = 1'b1;
                    end

                    if (i_jtag_halt_req && !w_run_redirect) begin
                        w_next_state = ST_DRAIN;
                        w_next_cnt   = CNT_LOAD;
                    end
                end

                ST_DRAIN: begin
                    // Fetch is frozen. The PC holds, and IF/ID gets a bubble
                    // each cycle so that only the ID..WB contents retire.
                    o_stall_vec[IDX_PC]    = 1'b1;
                    o_flush_vec[IDX_IF_ID] = 1'b1;

                    if (i_ex_busy) begin
                        o_stall_vec[IDX_IF_ID]  = 1'b1;
                        o_stall_vec[IDX_ID_EX]  = 1'b1;
                        o_flush_vec[IDX_EX_MEM] = 1'b1;
                    end else if (i_branch_taken) begin
                        // Do not redirect into a frozen fetch. Keep the target
                        // and replay it when the core resumes. The latest
                        // branch wins.
                        o_flush_vec[IDX_ID_EX] = 1'b1;
                        w_next_lat_vld         = 1'b1;
                        w_next_lat_pc          = i_pc_branch;
                    end else if (i_load_use) begin
                        o_stall_vec[IDX_IF_ID] = 1'b1;
                        o_flush_vec[IDX_ID_EX] = 1'b1;
                    end

                    // Only cycles where EX makes progress count toward the
                    // drain. A drop of halt_req here does not abort the drain.
                    if (!i_ex_busy) begin
                        if (r_cnt <= CNT_ONE) begin
                            w_next_cnt   = '0;
                            w_next_state = ST_HALTED;
                        end else begin
                            w_next_cnt = r_cnt - CNT_ONE;
                        end
                    end
                end

                ST_HALTED: begin
                    o_jtag_halt_ack        = 1'b1;
                    o_stall_vec[IDX_PC]    = 1'b1;
                    o_flush_vec[IDX_IF_ID] = 1'b1;
                    if (!i_jtag_halt_req) begin
                        w_next_state = ST_RESUME;
                    end
                end

                ST_RESUME: begin
                    // One cycle that replays a branch latched during the
                    // drain. The redirect also bubbles the instruction that
                    // fetch presented at the old PC.
                    if (r_lat_vld) begin
                        o_branch_taken         = 1'b1;
                        o_pc_branch            = r_lat_pc;
                        o_flush_vec[IDX_IF_ID] = 1'b1;
                        o_flush_vec[IDX_ID_EX] = 1'b1;
                    end
                    w_next_lat_vld = 1'b0;
                    w_next_lat_pc  = '0;
                    w_next_state   = ST_RUN;
                end

                default: begin
                    w_next_state   = ST_RUN;
                    w_next_cnt     = '0;
                    w_next_lat_vld = 1'b0;
                    w_next_lat_pc  = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_lat_vld <= 1'b0;
            r_lat_pc  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_lat_vld <= w_next_lat_vld;
            r_lat_pc  <= w_next_lat_pc;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
//
// Inputs change 1 ns after each rising edge. Outputs are checked 1 ns later,
// which is well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_jtag_rst;
    logic        i_jtag_halt_req;
    logic        o_jtag_halt_ack;
    logic        i_load_use;
    logic        i_ex_busy;
    logic        i_branch_taken;
    logic [31:0] i_pc_branch;
    logic        i_clint_req;
    logic        o_clint_assert;
    logic        o_branch_taken;
    logic [31:0] o_pc_branch;
    logic [4:0]  o_stall_vec;
    logic [4:0]  o_flush_vec;

    int total = 0;
    int bad   = 0;

    pipe_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_jtag_rst      (i_jtag_rst),
        .i_jtag_halt_req (i_jtag_halt_req),
        .o_jtag_halt_ack (o_jtag_halt_ack),
        .i_load_use      (i_load_use),
        .i_ex_busy       (i_ex_busy),
        .i_branch_taken  (i_branch_taken),
        .i_pc_branch     (i_pc_branch),
        .i_clint_req     (i_clint_req),
        .o_clint_assert  (o_clint_assert),
        .o_branch_taken  (o_branch_taken),
        .o_pc_branch     (o_pc_branch),
        .o_stall_vec     (o_stall_vec),
        .o_flush_vec     (o_flush_vec)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hr, input logic lu, input logic busy,
                         input logic br, input logic [31:0] pc, input logic clint);
        i_jtag_halt_req = hr;
        i_load_use      = lu;
        i_ex_busy       = busy;
        i_branch_taken  = br;
        i_pc_branch     = pc;
        i_clint_req     = clint;
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        i_jtag_rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0);
        #20;
        rst_n = 1'b1;
        cyc();
        drive(0, 0, 0, 0, 32'h0, 0);
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL reset_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        total++; if (o_flush_vec !== 5'b00000) begin bad++; $display("FAIL reset_flush got=%b exp=%b", o_flush_vec, 5'b00000); end
        total++; if (o_jtag_halt_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", o_jtag_halt_ack); end
        total++; if (o_clint_assert !== 1'b0) begin bad++; $display("FAIL reset_clint got=%b exp=0", o_clint_assert); end
        total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL reset_br got=%b exp=0", o_branch_taken); end
        total++; if (o_pc_branch !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", o_pc_branch); end
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 1, 32'h80, 0);
        total++; if (o_branch_taken !== 1'b1) begin bad++; $display("FAIL br_taken got=%b exp=1", o_branch_taken); end
        total++; if (o_pc_branch !== 32'h80) begin bad++; $display("FAIL br_pc got=%h exp=80", o_pc_branch); end
        total++; if (o_flush_vec !== 5'b00110) begin bad++; $display("FAIL br_flush got=%b exp=%b", o_flush_vec, 5'b00110); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL br_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        cyc();
        drive(0, 0, 0, 0, 32'h0, 0);
        cyc();
    endtask

    task automatic test_load_use();
        drive(0, 1, 0, 0, 32'h0, 0);
        total++; if (o_stall_vec !== 5'b00011) begin bad++; $display("FAIL lu_stall got=%b exp=%b", o_stall_vec, 5'b00011); end
        total++; if (o_flush_vec !== 5'b00100) begin bad++; $display("FAIL lu_flush got=%b exp=%b", o_flush_vec, 5'b00100); end
        cyc();
        drive(0, 1, 0, 1, 32'h44, 0);
        total++; if (o_branch_taken !== 1'b1) begin bad++; $display("FAIL lu_br_taken got=%b exp=1", o_branch_taken); end
        total++; if (o_pc_branch !== 32'h44) begin bad++; $display("FAIL lu_br_pc got=%h exp=44", o_pc_branch); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL lu_br_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        total++; if (o_flush_vec !== 5'b00110) begin bad++; $display("FAIL lu_br_flush got=%b exp=%b", o_flush_vec, 5'b00110); end
        cyc();
        drive(0, 0, 0, 0, 32'h0, 0);
        cyc();
    endtask

    task automatic test_busy();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 32'h120, 0);
            total++; if (o_stall_vec !== 5'b00111) begin bad++; $display("FAIL busy_stall[%0d] got=%b exp=%b", i, o_stall_vec, 5'b00111); end
            total++; if (o_flush_vec !== 5'b01000) begin bad++; $display("FAIL busy_flush[%0d] got=%b exp=%b", i, o_flush_vec, 5'b01000); end
            total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL busy_br[%0d] got=%b exp=0", i, o_branch_taken); end
            cyc();
        end
        drive(0, 0, 1, 0, 32'h0, 1);
        total++; if (o_clint_assert !== 1'b1) begin bad++; $display("FAIL busy_clint got=%b exp=1", o_clint_assert); end
        total++; if (o_flush_vec !== 5'b01110) begin bad++; $display("FAIL busy_clint_flush got=%b exp=%b", o_flush_vec, 5'b01110); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL busy_clint_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        cyc();
        drive(0, 0, 0, 0, 32'h0, 0);
        cyc();
    endtask

    task automatic test_halt();
        // The halt request is seen in RUN, so that cycle produces no outputs.
        drive(1, 0, 0, 0, 32'h0, 0);
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL halt_run_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        cyc();
        for (int k = 1; k <= 4; k++) begin
            total++; if (o_stall_vec !== 5'b00001) begin bad++; $display("FAIL drain_stall[%0d] got=%b exp=%b", k, o_stall_vec, 5'b00001); end
            total++; if (o_flush_vec !== 5'b00010) begin bad++; $display("FAIL drain_flush[%0d] got=%b exp=%b", k, o_flush_vec, 5'b00010); end
            total++; if (o_jtag_halt_ack !== 1'b0) begin bad++; $display("FAIL drain_ack[%0d] got=%b exp=0", k, o_jtag_halt_ack); end
            cyc();
        end
        total++; if (o_jtag_halt_ack !== 1'b1) begin bad++; $display("FAIL halted_ack got=%b exp=1", o_jtag_halt_ack); end
        total++; if (o_stall_vec !== 5'b00001) begin bad++; $display("FAIL halted_stall got=%b exp=%b", o_stall_vec, 5'b00001); end
        total++; if (o_flush_vec !== 5'b00010) begin bad++; $display("FAIL halted_flush got=%b exp=%b", o_flush_vec, 5'b00010); end
        drive(0, 0, 0, 0, 32'h0, 0);
        cyc();
        // RESUME with nothing latched.
        total++; if (o_jtag_halt_ack !== 1'b0) begin bad++; $display("FAIL resume_ack got=%b exp=0", o_jtag_halt_ack); end
        total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL resume_nobr got=%b exp=0", o_branch_taken); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL resume_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        cyc();
    endtask

    task automatic test_halt_busy();
        drive(1, 0, 0, 0, 32'h0, 0);
        cyc();
        for (int k = 1; k <= 6; k++) begin
            drive(1, 0, (k == 2 || k == 3), 0, 32'h0, 0);
            total++; if (o_jtag_halt_ack !== 1'b0) begin bad++; $display("FAIL hb_ack[%0d] got=%b exp=0", k, o_jtag_halt_ack); end
            if (k == 2) begin
                total++; if (o_stall_vec !== 5'b00111) begin bad++; $display("FAIL hb_busy_stall got=%b exp=%b", o_stall_vec, 5'b00111); end
                total++; if (o_flush_vec !== 5'b01010) begin bad++; $display("FAIL hb_busy_flush got=%b exp=%b", o_flush_vec, 5'b01010); end
            end
            cyc();
        end
        drive(1, 0, 0, 0, 32'h0, 0);
        total++; if (o_jtag_halt_ack !== 1'b1) begin bad++; $display("FAIL hb_ack7 got=%b exp=1", o_jtag_halt_ack); end
        drive(0, 0, 0, 0, 32'h0, 0);
        cyc();
        cyc();
    endtask

    task automatic test_drain_branch();
        drive(1, 0, 0, 0, 32'h0, 0);
        cyc();
        drive(1, 0, 0, 1, 32'h100, 0);
        total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL db_br got=%b exp=0", o_branch_taken); end
        total++; if (o_flush_vec !== 5'b00110) begin bad++; $display("FAIL db_flush got=%b exp=%b", o_flush_vec, 5'b00110); end
        total++; if (o_stall_vec !== 5'b00001) begin bad++; $display("FAIL db_stall got=%b exp=%b", o_stall_vec, 5'b00001); end
        cyc();
        drive(1, 0, 0, 1, 32'h200, 0);
        cyc();
        // Dropping halt_req mid-drain does not abort it. The clint is ignored here.
        drive(0, 0, 0, 0, 32'h0, 1);
        total++; if (o_clint_assert !== 1'b0) begin bad++; $display("FAIL db_clint got=%b exp=0", o_clint_assert); end
        cyc();
        cyc();
        total++; if (o_jtag_halt_ack !== 1'b1) begin bad++; $display("FAIL db_halted_ack got=%b exp=1", o_jtag_halt_ack); end
        total++; if (o_clint_assert !== 1'b0) begin bad++; $display("FAIL db_halted_clint got=%b exp=0", o_clint_assert); end
        cyc();
        total++; if (o_branch_taken !== 1'b1) begin bad++; $display("FAIL db_resume_br got=%b exp=1", o_branch_taken); end
        total++; if (o_pc_branch !== 32'h200) begin bad++; $display("FAIL db_resume_pc got=%h exp=200", o_pc_branch); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL db_resume_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        total++; if (o_clint_assert !== 1'b0) begin bad++; $display("FAIL db_resume_clint got=%b exp=0", o_clint_assert); end
        total++; if (o_jtag_halt_ack !== 1'b0) begin bad++; $display("FAIL db_resume_ack got=%b exp=0", o_jtag_halt_ack); end
        cyc();
        drive(0, 0, 0, 0, 32'h0, 0);
        total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL db_run_br got=%b exp=0", o_branch_taken); end
        total++; if (o_pc_branch !== 32'h0) begin bad++; $display("FAIL db_run_pc got=%h exp=0", o_pc_branch); end
        cyc();
    endtask

    task automatic test_jtag_rst();
        // Latch a target in DRAIN, then issue a debug reset while HALTED.
        drive(1, 0, 0, 0, 32'h0, 0);
        cyc();
        drive(1, 0, 0, 1, 32'h240, 0);
        cyc();
        drive(1, 0, 0, 0, 32'h0, 0);
        cyc();
        cyc();
        cyc();
        total++; if (o_jtag_halt_ack !== 1'b1) begin bad++; $display("FAIL jr_pre_ack got=%b exp=1", o_jtag_halt_ack); end
        i_jtag_rst = 1'b1;
        #1;
        total++; if (o_flush_vec !== 5'b11110) begin bad++; $display("FAIL jr_flush got=%b exp=%b", o_flush_vec, 5'b11110); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL jr_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL jr_br got=%b exp=0", o_branch_taken); end
        cyc();
        i_jtag_rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0);
        total++; if (o_jtag_halt_ack !== 1'b0) begin bad++; $display("FAIL jr_run_ack got=%b exp=0", o_jtag_halt_ack); end
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL jr_run_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        cyc();
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 32'h0, 0);
        cyc();
        drive(1, 0, 0, 1, 32'h300, 0);
        cyc();
        drive(1, 0, 0, 0, 32'h0, 0);
        rst_n = 1'b0;
        #1;
        total++; if (o_stall_vec !== 5'b00000) begin bad++; $display("FAIL ar_stall got=%b exp=%b", o_stall_vec, 5'b00000); end
        total++; if (o_flush_vec !== 5'b00000) begin bad++; $display("FAIL ar_flush got=%b exp=%b", o_flush_vec, 5'b00000); end
        drive(0, 0, 0, 0, 32'h0, 0);
        rst_n = 1'b1;
        cyc();
        // A fresh halt/resume cycle must not replay the dropped 0x300 target.
        drive(1, 0, 0, 0, 32'h0, 0);
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        drive(0, 0, 0, 0, 32'h0, 0);
        total++; if (o_jtag_halt_ack !== 1'b1) begin bad++; $display("FAIL ar_halted_ack got=%b exp=1", o_jtag_halt_ack); end
        cyc();
        total++; if (o_branch_taken !== 1'b0) begin bad++; $display("FAIL ar_resume_br got=%b exp=0", o_branch_taken); end
        total++; if (o_pc_branch !== 32'h0) begin bad++; $display("FAIL ar_resume_pc got=%h exp=0", o_pc_branch); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_use();
        test_busy();
        test_halt();
        test_halt_busy();
        test_drain_branch();
        test_jtag_rst();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
